// File: rtl/adc_stream_reader.sv
// adc_stream_reader: paced AD400x busy-mode reader with block
// averaging, fixed-point gain and output saturation.
module adc_stream_reader #(
  parameter int ADC_WIDTH       = 16,
  parameter int GAIN_WIDTH      = 16,
  parameter int GAIN_FRAC       = 8,
  parameter int CNV_HIGH_CYCLES = 4,
  parameter int BUSY_TIMEOUT    = 1023,
  parameter int MAX_AVG_LOG2    = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [15:0]           period,
  input  logic [GAIN_WIDTH-1:0] gain,
  input  logic [2:0]            avg_log2,
  input  logic                  clear_flags,
  input  logic                  data_in,
  output logic                  cnv,
  output logic                  sck,
  output logic                  sample_valid,
  output logic [ADC_WIDTH-1:0]  sample_data,
  output logic [ADC_WIDTH-1:0]  raw_data,
  output logic                  sample_sat,
  output logic                  busy_timeout,
  output logic                  overrun
);
  localparam int AW = ADC_WIDTH + MAX_AVG_LOG2;
  localparam int PW = AW + GAIN_WIDTH;
  localparam int CW = $clog2(CNV_HIGH_CYCLES + 1);
  localparam int WW = $clog2(BUSY_TIMEOUT + 1);
  localparam int BW = $clog2(ADC_WIDTH);
  localparam int NW = MAX_AVG_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CNV, S_WAIT, S_READ, S_ACCUM, S_OUTPUT
  } state_t;

  state_t state, state_nx;

  logic                  en_q;
  logic [15:0]           pcnt;
  logic                  tick;
  logic [CW-1:0]         cnv_cnt;
  logic [WW-1:0]         wait_cnt;
  logic [BW-1:0]         bit_idx;
  logic                  phase;
  logic [ADC_WIDTH-1:0]  shreg;
  logic [AW-1:0]         acc;
  logic [NW-1:0]         count;
  logic [GAIN_WIDTH-1:0] gain_q;
  logic [2:0]            avg_q;
  logic [2:0]            avg_clamp;
  logic                  timeout_ev;
  logic                  last_bit;
  logic                  blk_done;
  logic [NW-1:0]         count_nx;
  logic [AW-1:0]         avg;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         scaled;
  logic                  sat;

  // a fresh enable starts a conversion right away
  assign tick = enable && (!en_q || pcnt == period - 16'd1);

  assign avg_clamp = (int'(avg_log2) > MAX_AVG_LOG2) ?
                     3'(MAX_AVG_LOG2) : avg_log2;

  assign timeout_ev = (state == S_WAIT) && data_in &&
                      (wait_cnt == WW'(BUSY_TIMEOUT));
  assign last_bit   = (state == S_READ) && phase &&
                      (bit_idx == '0);
  assign count_nx   = count + NW'(1);
  assign blk_done   = count_nx == (NW'(1) << avg_q);

  assign avg    = acc >> avg_q;
  assign prod   = PW'(avg) * PW'(gain_q);
  assign scaled = prod >> GAIN_FRAC;
  assign sat    = |scaled[PW-1:ADC_WIDTH];

  always_ff @(posedge clk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (tick) state_nx = S_CNV;
      S_CNV:
        if (cnv_cnt == CW'(CNV_HIGH_CYCLES - 1))
          state_nx = S_WAIT;
      S_WAIT:
        if (!data_in)        state_nx = S_READ;
        else if (timeout_ev) state_nx = S_IDLE;
      S_READ:   if (last_bit) state_nx = S_ACCUM;
      S_ACCUM:  state_nx = blk_done ? S_OUTPUT : S_IDLE;
      S_OUTPUT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cnv = (state == S_CNV);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      en_q         <= 1'b0;
      pcnt         <= '0;
      cnv_cnt      <= '0;
      wait_cnt     <= '0;
      bit_idx      <= '0;
      phase        <= 1'b0;
      shreg        <= '0;
      acc          <= '0;
      count        <= '0;
      gain_q       <= '0;
      avg_q        <= '0;
      sck          <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      raw_data     <= '0;
      sample_sat   <= 1'b0;
      busy_timeout <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      en_q         <= enable;
      sample_valid <= 1'b0;
      sck          <= 1'b0;
      if (enable) pcnt <= tick ? '0 : pcnt + 16'd1;
      if (timeout_ev)       busy_timeout <= 1'b1;
      else if (clear_flags) busy_timeout <= 1'b0;
      if (tick && state != S_IDLE) overrun <= 1'b1;
      else if (clear_flags)        overrun <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnv_cnt <= '0;
          // gain and averaging are frozen for a whole block
          if (tick && count == '0) begin
            gain_q <= gain;
            avg_q  <= avg_clamp;
          end
        end
        S_CNV: begin
          cnv_cnt  <= cnv_cnt + CW'(1);
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + WW'(1);
          bit_idx  <= BW'(ADC_WIDTH - 1);
          phase    <= 1'b0;
          if (timeout_ev) begin
            acc   <= '0;
            count <= '0;
          end
        end
        S_READ: begin
          phase <= ~phase;
          sck   <= ~phase;
          if (phase) begin
            shreg   <= {shreg[ADC_WIDTH-2:0], data_in};
            bit_idx <= bit_idx - BW'(1);
          end
        end
        S_ACCUM: begin
          raw_data <= shreg;
          acc      <= acc + AW'(shreg);
          count    <= count_nx;
        end
        S_OUTPUT: begin
          sample_valid <= 1'b1;
          sample_data  <= sat ? '1 : scaled[ADC_WIDTH-1:0];
          sample_sat   <= sat;
          acc          <= '0;
          count        <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_stream_reader.sv
// tb_adc_stream_reader: directed + randomized checks against an
// AD400x busy-mode model and a block-average reference.
module tb_adc_stream_reader;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd100;
  logic [15:0] gain = 16'h0100;
  logic [2:0]  avg_log2 = 3'd0;
  logic        clear_flags = 1'b0;
  logic        data_in = 1'b1;
  logic        cnv, sck, sample_valid, sample_sat;
  logic        busy_timeout, overrun;
  logic [15:0] sample_data, raw_data;

  adc_stream_reader dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .period(period), .gain(gain), .avg_log2(avg_log2),
    .clear_flags(clear_flags), .data_in(data_in),
    .cnv(cnv), .sck(sck), .sample_valid(sample_valid),
    .sample_data(sample_data), .raw_data(raw_data),
    .sample_sat(sample_sat), .busy_timeout(busy_timeout),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ADC model: busy for busy_len cycles after CNV falls, then MSB first
  logic [15:0] adc_q[$];
  int          m_st = 0, m_cnt = 0, m_bit = 0;
  logic [15:0] m_word = '0;
  bit          hang = 1'b0;
  int          busy_len = 20;

  always @(negedge clk) begin
    if (!aresetn) begin
      m_st = 0;
      data_in = 1'b1;
    end else if (cnv) begin
      m_st = 1;
    end else begin
      case (m_st)
        1: begin m_st = 2; m_cnt = 0; data_in = 1'b1; end
        2: begin
          m_cnt++;
          if (m_cnt >= busy_len && !hang) begin
            data_in = 1'b0;
            m_st = 3;
            m_bit = 16;
            m_word = (adc_q.size() > 0) ? adc_q.pop_front()
                                        : 16'($urandom);
          end
        end
        3: if (sck) begin
          m_bit--;
          data_in = m_word[m_bit];
          if (m_bit == 0) m_st = 4;
        end
        4: if (!sck) begin data_in = 1'b1; m_st = 0; end
        default: ;
      endcase
    end
  end

  // monitor
  int          cyc = 0, cnv_rises = 0, cnv_run = 0, last_cnv_len = 0;
  int          sck_rises = 0, viol = 0, cnv_fall_cyc = 0, bt_cyc = 0;
  logic        cnv_p = 1'b0, sck_p = 1'b0, bt_p = 1'b0;
  logic [15:0] got_d[$], got_r[$];
  logic        got_s[$];
  int          got_sck[$], got_cyc[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cnv && !cnv_p) begin
      cnv_rises++; cnv_run = 0; sck_rises = 0;
    end
    if (cnv) cnv_run++;
    if (!cnv && cnv_p) begin
      last_cnv_len = cnv_run; cnv_fall_cyc = cyc;
    end
    if (sck && !sck_p) sck_rises++;
    if (sck && cnv) viol++;
    if (busy_timeout && !bt_p) bt_cyc = cyc;
    if (sample_valid) begin
      got_d.push_back(sample_data);
      got_s.push_back(sample_sat);
      got_r.push_back(raw_data);
      got_sck.push_back(sck_rises);
      got_cyc.push_back(cyc);
    end
    cnv_p = cnv; sck_p = sck; bt_p = busy_timeout;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] ref_out(input logic [15:0] w[$],
                                          input int lg, input int g);
    longint sum = 0;
    longint av, p;
    int e = (lg > 4) ? 4 : lg;
    foreach (w[i]) sum += longint'(w[i]);
    av = sum >> e;
    p = (av * g) >> 8;
    if (p > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, p[15:0]};
  endfunction

  task automatic wait_n(input int n, input int budget, input string tag);
    int k = 0;
    while (got_d.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    chk(tag, 32'(got_d.size() >= n), 32'd1);
  endtask

  task automatic chk_sample(input int i, input logic [16:0] exp,
                            input string tag);
    logic [15:0] d;
    logic s;
    d = (got_d.size() > i) ? got_d[i] : 16'hxxxx;
    s = (got_s.size() > i) ? got_s[i] : 1'bx;
    chk({tag, "_data"}, 32'(d), 32'(exp[15:0]));
    chk({tag, "_sat"}, 32'(s), 32'(exp[16]));
  endtask

  task automatic gap();
    enable = 1'b0;
    repeat (120) @(negedge clk);
    adc_q.delete();
    got_d.delete(); got_s.delete(); got_r.delete();
    got_sck.delete(); got_cyc.delete();
  endtask

  initial begin
    logic [15:0] w[$];
    logic [15:0] a, b, c;
    int lg, g, k, d, c0;
    logic [16:0] e;

    repeat (4) @(negedge clk);
    chk("rst_outs", 32'({cnv, sck, sample_valid, sample_sat,
                         busy_timeout, overrun}), 32'd0);
    chk("rst_data", 32'(sample_data), 32'd0);
    chk("rst_raw", 32'(raw_data), 32'd0);
    aresetn = 1'b1;

    repeat (3) adc_q.push_back(16'h1234);
    enable = 1'b1;
    wait_n(3, 500, "basic_cnt");
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_sample(i, {1'b0, 16'h1234}, "basic");
      chk("basic_raw", 32'((got_r.size() > i) ? got_r[i] : 16'hx),
          32'h1234);
      chk("basic_sck16", 32'((got_sck.size() > i) ? got_sck[i] : -1),
          32'd16);
    end
    chk("basic_interval",
        32'((got_cyc.size() > 2) ? got_cyc[2] - got_cyc[1] : -1),
        32'd100);
    chk("cnv_len", 32'(last_cnv_len), 32'd4);
    gap();

    gain = 16'h0200;
    adc_q.push_back(16'h9000);
    adc_q.push_back(16'h4000);
    enable = 1'b1;
    wait_n(2, 400, "gain_cnt");
    enable = 1'b0;
    chk_sample(0, {1'b1, 16'hFFFF}, "gain_sat");
    chk_sample(1, {1'b0, 16'h8000}, "gain_ok");
    gap();

    gain = 16'h0100;
    avg_log2 = 3'd2;
    w = '{16'd10, 16'd20, 16'd30, 16'd41};
    foreach (w[i]) adc_q.push_back(w[i]);
    enable = 1'b1;
    wait_n(1, 700, "avg_cnt");
    enable = 1'b0;
    chk_sample(0, ref_out(w, 2, 256), "avg4");
    chk("avg4_raw", 32'((got_r.size() > 0) ? got_r[0] : 16'hx), 32'd41);
    chk("avg4_single", 32'(got_d.size()), 32'd1);
    gap();

    for (int it = 0; it < 6; it++) begin
      lg = int'($urandom_range(0, 7));
      g = int'($urandom_range(0, 16'h0400));
      gain = 16'(g);
      avg_log2 = 3'(lg);
      w.delete();
      for (int j = 0; j < (1 << ((lg > 4) ? 4 : lg)); j++)
        w.push_back(16'($urandom));
      foreach (w[i]) adc_q.push_back(w[i]);
      enable = 1'b1;
      wait_n(1, (w.size() + 2) * 100, "rnd_cnt");
      enable = 1'b0;
      chk_sample(0, ref_out(w, lg, g), "rnd");
      gap();
    end

    gain = 16'h0100;
    avg_log2 = 3'd1;
    period = 16'd1200;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    adc_q.push_back(a);
    enable = 1'b1;
    k = 0;
    while (raw_data !== a && k < 300) begin @(negedge clk); k++; end
    chk("to_first_raw", 32'(raw_data), 32'(a));
    hang = 1'b1;
    k = 0;
    while (busy_timeout !== 1'b1 && k < 2600) begin
      @(negedge clk); k++;
    end
    chk("to_flag", 32'(busy_timeout), 32'd1);
    d = bt_cyc - cnv_fall_cyc;
    chk("to_delay", 32'(d >= 1023 && d <= 1025), 32'd1);
    chk("to_no_valid", 32'(got_d.size()), 32'd0);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    @(negedge clk);
    chk("to_clear", 32'(busy_timeout), 32'd0);
    hang = 1'b0;
    gap();
    period = 16'd100;
    adc_q.push_back(b);
    adc_q.push_back(c);
    w = '{b, c};
    enable = 1'b1;
    wait_n(1, 500, "to_after_cnt");
    enable = 1'b0;
    chk_sample(0, ref_out(w, 1, 256), "to_after");
    gap();

    avg_log2 = 3'd0;
    period = 16'd30;
    chk("ovr_pre", 32'(overrun), 32'd0);
    w.delete();
    for (int j = 0; j < 8; j++) w.push_back(16'($urandom));
    foreach (w[i]) adc_q.push_back(w[i]);
    c0 = cnv_rises;
    enable = 1'b1;
    wait_n(3, 600, "ovr_cnt");
    enable = 1'b0;
    repeat (120) @(negedge clk);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_cnv_eq_valid", 32'(cnv_rises - c0), 32'(got_d.size()));
    for (int i = 0; i < 3; i++)
      chk_sample(i, {1'b0, w[i]}, "ovr");
    period = 16'd100;
    gap();

    a = 16'($urandom); b = 16'($urandom);
    adc_q.push_back(a);
    enable = 1'b1;
    k = 0;
    while (!(m_st == 3 && m_bit == 7) && k < 300) begin
      @(negedge clk); k++;
    end
    chk("mid_read_reached", 32'(m_st == 3 && m_bit == 7), 32'd1);
    aresetn = 1'b0;
    @(posedge clk);
    #2;
    chk("mr_sck", 32'(sck), 32'd0);
    chk("mr_outs", 32'({cnv, sample_valid, sample_sat,
                        busy_timeout, overrun}), 32'd0);
    chk("mr_data", 32'({sample_data, raw_data}), 32'd0);
    repeat (3) @(negedge clk);
    adc_q.delete();
    got_d.delete(); got_s.delete(); got_r.delete();
    adc_q.push_back(b);
    aresetn = 1'b1;
    wait_n(1, 300, "mr_after_cnt");
    enable = 1'b0;
    chk_sample(0, {1'b0, b}, "mr_after");
    chk("mr_after_raw", 32'((got_r.size() > 0) ? got_r[0] : 16'hx),
        32'(b));
    chk("sck_cnv_overlap", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
